vga_sync_gen: RTL

Timing generator and pixel output stage for the 640×480@60 Hz VGA port. It derives a 25 MHz pixel tick from the 100 MHz system clock and runs horizontal and vertical counters. It presents the current pixel address (`ADDRH`/`ADDRV`) to the colour-generation logic and takes back a 12-bit colour (`COLOUR_IN`). It then drives the registered, blanked `VGA_COLOUR`, `VGA_HS` and `VGA_VS` pins, plus a once-per-frame tick used by animation counters.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_pixel_tick.sv | 31 +++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, word widths and small helpers.
package vga_pkg;

  localparam int unsigned COLOUR_W = 12;
  localparam int unsigned CNT_W    = 10;

  // 640x480@60 Hz horizontal timing, in pixels
  localparam int unsigned DEF_H_DISP       = 640;
  localparam int unsigned DEF_H_FP         = 16;
  localparam int unsigned DEF_H_SYNC       = 96;
  localparam int unsigned DEF_H_BP         = 48;
  localparam int unsigned DEF_H_TOTAL      = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_H_SYNC_START = DEF_H_DISP + DEF_H_FP;
  localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;

  // 640x480@60 Hz vertical timing, in lines
  localparam int unsigned DEF_V_DISP       = 480;
  localparam int unsigned DEF_V_FP         = 10;
  localparam int unsigned DEF_V_SYNC       = 2;
  localparam int unsigned DEF_V_BP         = 33;
  localparam int unsigned DEF_V_TOTAL      = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_V_SYNC_START = DEF_V_DISP + DEF_V_FP;
  localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [COLOUR_W-1:0] colour_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  // True when lo <= val < hi_excl
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi_excl);
    return (val >= lo) && (val < hi_excl);
  endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: one-cycle PIX_TICK every CLK_DIV system clocks.
module vga_pixel_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic PIX_TICK
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Free-running 0..CLK_DIV-1 counter; explicit wrap covers non-power-of-two dividers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Tick marks the last system clock of each pixel
  always_comb begin
    PIX_TICK = (div_cnt == DIV_LAST);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, address outputs, blanked and
// registered colour/sync pins, and a once-per-frame tick.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_DISP  = DEF_H_DISP,
  parameter int unsigned H_FP    = DEF_H_FP,
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BP    = DEF_H_BP,
  parameter int unsigned V_DISP  = DEF_V_DISP,
  parameter int unsigned V_FP    = DEF_V_FP,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BP    = DEF_V_BP
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [11:0]   COLOUR_IN,
  output logic [9:0]    ADDRH,
  output logic [8:0]    ADDRV,
  output logic [11:0]   VGA_COLOUR,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          FRAME_TICK
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_DISP_END = cnt_t'(H_DISP);
  localparam cnt_t V_DISP_END = cnt_t'(V_DISP);
  localparam cnt_t HS_START   = cnt_t'(H_DISP + H_FP);
  localparam cnt_t HS_END     = cnt_t'(H_DISP + H_FP + H_SYNC);
  localparam cnt_t VS_START   = cnt_t'(V_DISP + V_FP);
  localparam cnt_t VS_END     = cnt_t'(V_DISP + V_FP + V_SYNC);

  logic pix_tick;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic disp;
  logic h_last;
  logic v_last;
  logic hs_active;
  logic vs_active;

  vga_pixel_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pixel_tick (
    .CLK     (CLK),
    .RESET   (RESET),
    .PIX_TICK(pix_tick)
  );

  // Decode the current counter position
  always_comb begin
    disp      = (h_cnt < H_DISP_END) && (v_cnt < V_DISP_END);
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    hs_active = in_window(h_cnt, HS_START, HS_END);
    vs_active = in_window(v_cnt, VS_START, VS_END);
  end

  // Horizontal and vertical position counters, advanced once per pixel
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pixel address to colour logic; clipped to 0 outside the visible window
  always_comb begin
    ADDRH = disp ? h_cnt : '0;
    ADDRV = disp ? v_cnt[8:0] : '0;
  end

  // Frame start: last system clock of the last pixel of the last line
  always_comb begin
    FRAME_TICK = pix_tick && h_last && v_last;
  end

  // Pin registers: colour and both syncs share the same one-pixel lag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      VGA_COLOUR <= '0;
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
    end else if (pix_tick) begin
      VGA_COLOUR <= disp ? COLOUR_IN : '0;
      VGA_HS     <= ~hs_active;
      VGA_VS     <= ~vs_active;
    end
  end

endmodule
